// File: rtl/vector_decode_pkg.sv
// Shared vector package: instruction widths, opcodes, raw word layouts and
// the decoded bundle consumed by the issue/scoreboard stage.
package vector_decode_pkg;

    localparam int OPCODE_W = 7;
    localparam int VIDX_W   = 8;
    localparam int RIDX_W   = 8;
    localparam int IMM_W    = 8;
    localparam int DTYPE_W  = 2;
    localparam int INSTR_W  = 32;

    localparam logic [OPCODE_W-1:0] OPC_VADD   = 7'h10;
    localparam logic [OPCODE_W-1:0] OPC_VSUB   = 7'h11;
    localparam logic [OPCODE_W-1:0] OPC_VMUL   = 7'h12;
    localparam logic [OPCODE_W-1:0] OPC_VDIV   = 7'h13;
    localparam logic [OPCODE_W-1:0] OPC_VADDI  = 7'h20;
    localparam logic [OPCODE_W-1:0] OPC_VSUBI  = 7'h21;
    localparam logic [OPCODE_W-1:0] OPC_VMULI  = 7'h22;
    localparam logic [OPCODE_W-1:0] OPC_VLOAD  = 7'h40;
    localparam logic [OPCODE_W-1:0] OPC_VSTORE = 7'h41;

    localparam logic [2:0] MTYPE_MARK = 3'b111;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_M   = 2'd2,
        FMT_ILL = 2'd3
    } fmt_t;

    typedef enum logic [3:0] {
        UOP_VADD   = 4'd0,
        UOP_VSUB   = 4'd1,
        UOP_VMUL   = 4'd2,
        UOP_VDIV   = 4'd3,
        UOP_VADDI  = 4'd4,
        UOP_VSUBI  = 4'd5,
        UOP_VMULI  = 4'd6,
        UOP_VLOAD  = 4'd7,
        UOP_VSTORE = 4'd8,
        UOP_ILL    = 4'd15
    } uop_t;

    typedef struct packed {
        logic                mask;
        logic [VIDX_W-1:0]   vd;
        logic [VIDX_W-1:0]   vs1;
        logic [VIDX_W-1:0]   vs2;
        logic [OPCODE_W-1:0] opcode;
    } r_instr_t;

    typedef struct packed {
        logic                mask;
        logic [VIDX_W-1:0]   vd;
        logic [VIDX_W-1:0]   vs1;
        logic [IMM_W-1:0]    imm;
        logic [OPCODE_W-1:0] opcode;
    } i_instr_t;

    typedef struct packed {
        logic                swizzle;
        logic                transpose;
        logic [DTYPE_W-1:0]  dtype;
        logic [VIDX_W-1:0]   vd;
        logic                mask;
        logic [RIDX_W-1:0]   rs1;
        logic                sp;
        logic [OPCODE_W-1:0] opcode;
        logic [2:0]          mtype;
    } m_instr_t;

    typedef struct packed {
        fmt_t               fmt;
        uop_t               uop;
        logic [VIDX_W-1:0]  vd;
        logic [VIDX_W-1:0]  vs1;
        logic [VIDX_W-1:0]  vs2;
        logic [RIDX_W-1:0]  rs1;
        logic [IMM_W-1:0]   imm;
        logic               mask;
        logic [DTYPE_W-1:0] dtype;
        logic               transpose;
        logic               swizzle;
        logic               sp;
    } decoded_t;

    function automatic uop_t uop_of(input logic [OPCODE_W-1:0] opc);
        case (opc)
            OPC_VADD:   return UOP_VADD;
            OPC_VSUB:   return UOP_VSUB;
            OPC_VMUL:   return UOP_VMUL;
            OPC_VDIV:   return UOP_VDIV;
            OPC_VADDI:  return UOP_VADDI;
            OPC_VSUBI:  return UOP_VSUBI;
            OPC_VMULI:  return UOP_VMULI;
            OPC_VLOAD:  return UOP_VLOAD;
            OPC_VSTORE: return UOP_VSTORE;
            default:    return UOP_ILL;
        endcase
    endfunction

endpackage

// File: rtl/vector_decode_comb.sv
// Combinational instruction word -> decoded_t classifier and field extractor.
module vector_decode_comb
    import vector_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decoded_t           dec
);

    r_instr_t ri;
    i_instr_t ii;
    m_instr_t mi;

    assign ri = r_instr_t'(instr);
    assign ii = i_instr_t'(instr);
    assign mi = m_instr_t'(instr);

    // M-type wins over the other formats; fields not carried by a format stay zero
    always_comb begin
        dec = '0;
        if (mi.mtype == MTYPE_MARK && (mi.opcode == OPC_VLOAD || mi.opcode == OPC_VSTORE)) begin
            dec.fmt       = FMT_M;
            dec.uop       = uop_of(mi.opcode);
            dec.swizzle   = mi.swizzle;
            dec.transpose = mi.transpose;
            dec.dtype     = mi.dtype;
            dec.vd        = mi.vd;
            dec.mask      = mi.mask;
            dec.rs1       = mi.rs1;
            dec.sp        = mi.sp;
        end else if (ri.opcode inside {OPC_VADD, OPC_VSUB, OPC_VMUL, OPC_VDIV}) begin
            dec.fmt  = FMT_R;
            dec.uop  = uop_of(ri.opcode);
            dec.mask = ri.mask;
            dec.vd   = ri.vd;
            dec.vs1  = ri.vs1;
            dec.vs2  = ri.vs2;
        end else if (ii.opcode inside {OPC_VADDI, OPC_VSUBI, OPC_VMULI}) begin
            dec.fmt  = FMT_I;
            dec.uop  = uop_of(ii.opcode);
            dec.mask = ii.mask;
            dec.vd   = ii.vd;
            dec.vs1  = ii.vs1;
            dec.imm  = ii.imm;
        end else begin
            dec.fmt = FMT_ILL;
            dec.uop = UOP_ILL;
        end
    end

endmodule

// File: rtl/vector_decode.sv
// Registered decode stage: output register plus one skid entry between two
// valid/ready handshakes, with a saturating count of accepted illegal words.
module vector_decode
    import vector_decode_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output decoded_t           out_dec,
    output logic [15:0]        illegal_cnt
);

    decoded_t dec_p0;
    decoded_t skid_dec;
    logic     skid_vld;
    logic     accept;
    logic     drain;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    vector_decode_comb u_comb (
        .instr (in_instr),
        .dec   (dec_p0)
    );

    // in_ready comes straight from a flop so out_ready never reaches it
    assign in_ready = ~skid_vld;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    // ---- stage boundary: decoded word -> output register / skid entry ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid   <= 1'b0;
            out_dec     <= '0;
            skid_vld    <= 1'b0;
            skid_dec    <= '0;
            illegal_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
                skid_vld  <= 1'b0;
            end else if (drain || !out_valid) begin
                if (skid_vld) begin
                    out_dec   <= skid_dec;
                    out_valid <= 1'b1;
                    skid_vld  <= 1'b0;
                end else begin
                    out_valid <= accept;
                    if (accept) out_dec <= dec_p0;
                end
            end else if (accept) begin
                skid_dec <= dec_p0;
                skid_vld <= 1'b1;
            end
            if (accept && !flush && dec_p0.fmt == FMT_ILL)
                illegal_cnt <= sat_inc(illegal_cnt);
        end
    end

endmodule

// File: tb/tb_vector_decode.sv
// Directed bench for vector_decode: decode vector table plus buffering,
// flush, reset and counter saturation sequences.
module tb_vector_decode;
    import vector_decode_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    decoded_t    out_dec;
    logic [15:0] illegal_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [31:0] instr;
        decoded_t    exp;
    } vec_t;

    vec_t     vecs[12];
    decoded_t got[$];

    vector_decode dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dec     (out_dec),
        .illegal_cnt (illegal_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic decoded_t mk(input logic [1:0] f, input logic [3:0] u,
                                    input logic [7:0] vd, input logic [7:0] vs1,
                                    input logic [7:0] vs2, input logic [7:0] rs1,
                                    input logic [7:0] imm, input logic m,
                                    input logic [1:0] dt, input logic tr,
                                    input logic sw, input logic sp);
        decoded_t d;
        d.fmt = fmt_t'(f);
        d.uop = uop_t'(u);
        d.vd = vd;
        d.vs1 = vs1;
        d.vs2 = vs2;
        d.rs1 = rs1;
        d.imm = imm;
        d.mask = m;
        d.dtype = dt;
        d.transpose = tr;
        d.swizzle = sw;
        d.sp = sp;
        return d;
    endfunction

    task automatic check_vec(input int k);
        chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(1'b1));
        chk($sformatf("vec%0d_dec", k), 64'(out_dec), 64'(vecs[k].exp));
        if (vecs[k].exp.fmt == FMT_ILL) exp_cnt++;
        chk($sformatf("vec%0d_illcnt", k), 64'(illegal_cnt), 64'(exp_cnt));
    endtask

    initial begin
        int idx;
        bit take;

        vecs[0]  = '{32'h81828390, mk(2'd0, 4'd0, 8'h03, 8'h05, 8'h07, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[1]  = '{32'h00817FA0, mk(2'd1, 4'd4, 8'h01, 8'h02, 8'h00, 8'h00, 8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[2]  = '{32'h60404E07, mk(2'd2, 4'd7, 8'h04, 8'h00, 8'h00, 8'h09, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1)};
        vecs[3]  = '{32'h0000007F, mk(2'd3, 4'd15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[4]  = '{32'h55E6F793, mk(2'd0, 4'd3, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[5]  = '{32'hC000AD22, mk(2'd1, 4'd6, 8'h80, 8'h01, 8'h00, 8'h00, 8'h5A, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[6]  = '{32'h9FF9E20F, mk(2'd2, 4'd8, 8'hFF, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0)};
        vecs[7]  = '{32'hFFFFFF94, mk(2'd3, 4'd15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[8]  = '{32'h00000217, mk(2'd3, 4'd15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[9]  = '{32'h00000023, mk(2'd3, 4'd15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[10] = '{32'h00000011, mk(2'd0, 4'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
        vecs[11] = '{32'h00000021, mk(2'd1, 4'd5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_out_dec", 64'(out_dec), 64'h0);
        chk("rst_illcnt", 64'(illegal_cnt), 64'h0);
        nRST = 1'b1;

        // Back-to-back decode table with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (i > 0) check_vec(i - 1);
            chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'(1'b1));
            in_instr = vecs[i].instr;
            in_valid = 1'b1;
        end
        @(negedge CLK);
        check_vec(11);
        in_valid = 1'b0;
        @(negedge CLK);
        chk("stream_drained", 64'(out_valid), 64'(1'b0));

        // Backpressure: offer 4 words, only 2 fit
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            in_instr = vecs[idx].instr;
            in_valid = 1'b1;
            take = in_ready;
            @(posedge CLK);
            if (take) idx++;
        end
        @(negedge CLK);
        in_valid = 1'b0;
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'(1'b0));
        chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
        chk("bp_hold0", 64'(out_dec), 64'(vecs[0].exp));
        @(negedge CLK);
        chk("bp_hold1", 64'(out_dec), 64'(vecs[0].exp));
        chk("bp_illcnt", 64'(illegal_cnt), 64'(exp_cnt));
        out_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge CLK);
            if (out_valid) got.push_back(out_dec);
        end
        chk("bp_count", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            chk("bp_order0", 64'(got[0]), 64'(vecs[0].exp));
            chk("bp_order1", 64'(got[1]), 64'(vecs[1].exp));
        end
        chk("bp_in_ready_back", 64'(in_ready), 64'(1'b1));

        // Flush with two words held and a simultaneous in_valid
        out_ready = 1'b0;
        @(negedge CLK);
        in_instr = vecs[2].instr;
        in_valid = 1'b1;
        @(negedge CLK);
        in_instr = vecs[4].instr;
        @(negedge CLK);
        chk("flA_full", 64'(in_ready), 64'(1'b0));
        in_instr = 32'h0000007F;
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flA_out_valid", 64'(out_valid), 64'(1'b0));
        chk("flA_in_ready", 64'(in_ready), 64'(1'b1));
        chk("flA_illcnt", 64'(illegal_cnt), 64'(exp_cnt));

        // Flush while an illegal word is actually accepted: dropped, not counted
        @(negedge CLK);
        in_instr = vecs[0].instr;
        in_valid = 1'b1;
        @(negedge CLK);
        in_instr = 32'h0000007F;
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flB_out_valid", 64'(out_valid), 64'(1'b0));
        chk("flB_illcnt", 64'(illegal_cnt), 64'(exp_cnt));
        @(negedge CLK);
        chk("flB_still_empty", 64'(out_valid), 64'(1'b0));

        // Asynchronous reset mid-stream with two words held
        @(negedge CLK);
        in_instr = vecs[1].instr;
        in_valid = 1'b1;
        @(negedge CLK);
        in_instr = vecs[3].instr;
        @(negedge CLK);
        in_valid = 1'b0;
        exp_cnt++;
        chk("ar_illcnt_before", 64'(illegal_cnt), 64'(exp_cnt));
        #2 nRST = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'(1'b0));
        chk("ar_in_ready", 64'(in_ready), 64'(1'b1));
        chk("ar_out_dec", 64'(out_dec), 64'h0);
        chk("ar_illcnt", 64'(illegal_cnt), 64'h0);
        exp_cnt = 0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("ar_after_release", 64'(out_valid), 64'(1'b0));

        // Counter saturation
        out_ready = 1'b1;
        in_instr = 32'h0000007F;
        in_valid = 1'b1;
        repeat (65534) @(negedge CLK);
        chk("sat_fffe", 64'(illegal_cnt), 64'hFFFE);
        @(negedge CLK);
        chk("sat_ffff", 64'(illegal_cnt), 64'hFFFF);
        repeat (10) @(negedge CLK);
        in_valid = 1'b0;
        chk("sat_hold", 64'(illegal_cnt), 64'hFFFF);
        chk("sat_last_dec", 64'(out_dec), 64'(vecs[3].exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
